// File: rtl/sonar_pkg.sv
// Shared constants for the sonar measurement slice: state codes, default
// timing for a 50MHz clock and the BCD digit width.
package sonar_pkg;

  localparam int TRIG_CICLOS_PADRAO    = 500;        // 10us @ 50MHz
  localparam int TIMEOUT_CICLOS_PADRAO = 1_500_000;  // 30ms @ 50MHz
  localparam int BCD_W                 = 4;

  localparam logic [2:0] ST_INICIAL  = 3'd0;
  localparam logic [2:0] ST_PREPARA  = 3'd1;
  localparam logic [2:0] ST_TRIGGER  = 3'd2;
  localparam logic [2:0] ST_ESPERA   = 3'd3;
  localparam logic [2:0] ST_MEDE     = 3'd4;
  localparam logic [2:0] ST_ARMAZENA = 3'd5;
  localparam logic [2:0] ST_FINAL    = 3'd6;
  localparam logic [2:0] ST_ERRO     = 3'd7;

  typedef enum logic [2:0] {
    INICIAL  = ST_INICIAL,
    PREPARA  = ST_PREPARA,
    TRIGGER  = ST_TRIGGER,
    ESPERA   = ST_ESPERA,
    MEDE     = ST_MEDE,
    ARMAZENA = ST_ARMAZENA,
    FINAL    = ST_FINAL,
    ERRO     = ST_ERRO
  } estado_t;

endpackage

// File: rtl/controle_medida_sonar_contador_m.sv
// Mod-M up counter with synchronous clear and enable; 'fim' flags count == M-1.
module contador_m #(
  parameter int M = 10,
  parameter int N = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      if (q == N'(M - 1)) q <= '0;
      else                q <= q + N'(1);
    end
  end

  assign fim = (q == N'(M - 1));

endmodule

// File: rtl/controle_medida_sonar.sv
// Sequences one ultrasonic measurement: clear contador_cm, fire the trigger,
// wait for echo and contador_cm 'pronto', latch the BCD distance or flag timeout.
module controle_medida_sonar
  import sonar_pkg::*;
#(
  parameter int TRIG_CICLOS    = TRIG_CICLOS_PADRAO,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  parameter int W_TMO          = 21
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 medir,
  input  logic                 echo,
  input  logic                 fim_contador,
  input  logic [BCD_W-1:0]     digito0_in,
  input  logic [BCD_W-1:0]     digito1_in,
  input  logic [BCD_W-1:0]     digito2_in,
  output logic                 zera_contador,
  output logic                 trigger,
  output logic [3*BCD_W-1:0]   medida,
  output logic                 pronto,
  output logic                 erro,
  output logic [3:0]           db_estado
);

  localparam int W_TRIG = (TRIG_CICLOS > 1) ? $clog2(TRIG_CICLOS) : 1;

  estado_t estado;
  logic    echo_p0, echo_p1;
  logic    zera_cont, conta_trig, conta_tmo;
  logic    fim_trig, fim_tmo;

  // echo synchronizer: echo_p1 is the only echo seen by the FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_p0 <= 1'b0;
      echo_p1 <= 1'b0;
    end else begin
      echo_p0 <= echo;
      echo_p1 <= echo_p0;
    end
  end

  // Timeout enable is gated by its own 'fim' so the counter parks at the limit.
  assign zera_cont  = (estado == PREPARA);
  assign conta_trig = (estado == TRIGGER);
  assign conta_tmo  = ((estado == ESPERA) || (estado == MEDE)) && !fim_tmo;

  contador_m #(.M(TRIG_CICLOS), .N(W_TRIG)) u_cont_trig (
    .clock (clock),
    .reset (reset),
    .zera  (zera_cont),
    .conta (conta_trig),
    .fim   (fim_trig)
  );

  contador_m #(.M(TIMEOUT_CICLOS), .N(W_TMO)) u_cont_tmo (
    .clock (clock),
    .reset (reset),
    .zera  (zera_cont),
    .conta (conta_tmo),
    .fim   (fim_tmo)
  );

  // Outputs are set on the transition into the state that owns them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= INICIAL;
      zera_contador <= 1'b0;
      trigger       <= 1'b0;
      pronto        <= 1'b0;
      erro          <= 1'b0;
      medida        <= '0;
    end else begin
      zera_contador <= 1'b0;
      trigger       <= 1'b0;
      pronto        <= 1'b0;
      case (estado)
        INICIAL: begin
          if (medir) begin
            estado        <= PREPARA;
            zera_contador <= 1'b1;
            erro          <= 1'b0;
          end
        end
        PREPARA: begin
          estado  <= TRIGGER;
          trigger <= 1'b1;
        end
        TRIGGER: begin
          if (fim_trig) estado  <= ESPERA;
          else          trigger <= 1'b1;
        end
        ESPERA: begin
          if (echo_p1) begin
            estado <= MEDE;
          end else if (fim_tmo) begin
            estado <= ERRO;
            erro   <= 1'b1;
          end
        end
        MEDE: begin
          if (fim_contador) begin
            estado <= ARMAZENA;
          end else if (fim_tmo) begin
            estado <= ERRO;
            erro   <= 1'b1;
          end
        end
        ARMAZENA: begin
          medida <= {digito2_in, digito1_in, digito0_in};
          estado <= FINAL;
          pronto <= 1'b1;
        end
        FINAL:   estado <= INICIAL;
        ERRO:    estado <= INICIAL;
        default: estado <= INICIAL;
      endcase
    end
  end

  assign db_estado = {1'b0, estado};

endmodule

// File: tb/tb_controle_medida_sonar.sv
// Directed plus randomized bench for controle_medida_sonar with a small outcome model.
module tb_controle_medida_sonar;

  localparam int TRIG = 10;
  localparam int TMO  = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        medir = 1'b0;
  logic        echo = 1'b0;
  logic        fim_contador = 1'b0;
  logic [3:0]  d0 = '0, d1 = '0, d2 = '0;
  logic        zera_contador, trigger, pronto, erro;
  logic [11:0] medida;
  logic [3:0]  db_estado;

  controle_medida_sonar #(
    .TRIG_CICLOS    (TRIG),
    .TIMEOUT_CICLOS (TMO),
    .W_TMO          (11)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .medir         (medir),
    .echo          (echo),
    .fim_contador  (fim_contador),
    .digito0_in    (d0),
    .digito1_in    (d1),
    .digito2_in    (d2),
    .zera_contador (zera_contador),
    .trigger       (trigger),
    .medida        (medida),
    .pronto        (pronto),
    .erro          (erro),
    .db_estado     (db_estado)
  );

  always #10 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pronto_cnt = 0;
  int zera_cnt = 0;
  int trig_len = 0;
  int since_fall = 0;
  int erro_lat = -1;
  bit trig_prev = 1'b0;
  bit erro_prev = 1'b0;
  bit fell = 1'b0;
  logic [11:0] exp_medida;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bcd_of(input int cm);
    logic [3:0] c, d, u;
    c = 4'(cm / 100);
    d = 4'((cm / 10) % 10);
    u = 4'(cm % 10);
    return {c, d, u};
  endfunction

  // One clock: sample outputs 1 time unit after the rising edge and update monitors.
  task automatic tick();
    @(posedge clock);
    #1;
    if (pronto === 1'b1) pronto_cnt++;
    if (zera_contador === 1'b1) zera_cnt++;
    if (trigger === 1'b1) trig_len++;
    fell = trig_prev && !trigger;
    if (fell) since_fall = 0;
    else      since_fall++;
    if (!erro_prev && erro) erro_lat = since_fall;
    trig_prev = trigger;
    erro_prev = erro;
  endtask

  task automatic start_meas();
    trig_len = 0;
    medir = 1'b1;
    tick();
    medir = 1'b0;
  endtask

  task automatic wait_fall();
    fell = 1'b0;
    for (int i = 0; i < 100 && !fell; i++) tick();
    check("trigger_fall_seen", fell, 1);
    check("trigger_width", trig_len, TRIG);
  endtask

  task automatic wait_erro();
    erro_lat = -1;
    for (int i = 0; i < TMO + 100 && !erro; i++) tick();
    check("erro_latency", erro_lat, TMO);
  endtask

  task automatic echo_meas(input int dly, input int width, input logic [11:0] val);
    {d2, d1, d0} = val;
    repeat (dly) tick();
    echo = 1'b1;
    repeat (width) tick();
    echo = 1'b0;
    repeat (3) tick();
    fim_contador = 1'b1;
    tick();
    fim_contador = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, z, mode, cm, dly, width;
    exp_medida = 12'h000;

    // Reset state
    repeat (100) tick();
    check("rst_trigger", trigger, 0);
    check("rst_zera", zera_contador, 0);
    check("rst_medida", medida, 0);
    check("rst_pronto", pronto, 0);
    check("rst_erro", erro, 0);
    check("rst_estado", db_estado, 0);
    reset = 1'b0;
    tick();

    // 1: nominal measurement, 100cm
    p = pronto_cnt;
    start_meas();
    check("t1_zera", zera_contador, 1);
    check("t1_estado_prepara", db_estado, 1);
    wait_fall();
    echo_meas(20, 1000, 12'h100);
    exp_medida = 12'h100;
    check("t1_pronto_once", pronto_cnt, p + 1);
    check("t1_medida", medida, exp_medida);
    check("t1_erro", erro, 0);
    check("t1_estado_idle", db_estado, 0);

    // 2: 75cm, zera pulsed once per measurement
    z = zera_cnt;
    start_meas();
    wait_fall();
    echo_meas(50, 750, 12'h075);
    exp_medida = 12'h075;
    check("t2_medida", medida, exp_medida);
    check("t2_zera_once", zera_cnt, z + 1);

    // 3: no echo -> timeout, medida held
    p = pronto_cnt;
    start_meas();
    wait_fall();
    wait_erro();
    check("t3_no_pronto", pronto_cnt, p);
    check("t3_medida_held", medida, exp_medida);
    tick();
    check("t3_erro_held", erro, 1);

    // 4: echo stuck high -> timeout; next medir clears erro in PREPARA
    start_meas();
    check("t4_erro_cleared_a", erro, 0);
    wait_fall();
    repeat (5) tick();
    echo = 1'b1;
    wait_erro();
    echo = 1'b0;
    repeat (4) tick();
    check("t4_erro_held", erro, 1);
    start_meas();
    check("t4_erro_cleared_b", erro, 0);
    check("t4_estado_prepara", db_estado, 1);
    wait_fall();
    echo_meas(10, 100, 12'h321);
    exp_medida = 12'h321;
    check("t4_medida", medida, exp_medida);

    // 5: medir during MEDE ignored
    p = pronto_cnt;
    z = zera_cnt;
    start_meas();
    wait_fall();
    {d2, d1, d0} = 12'h456;
    repeat (5) tick();
    echo = 1'b1;
    repeat (20) tick();
    check("t5_estado_mede", db_estado, 4);
    medir = 1'b1;
    tick();
    medir = 1'b0;
    repeat (20) tick();
    echo = 1'b0;
    repeat (3) tick();
    fim_contador = 1'b1;
    tick();
    fim_contador = 1'b0;
    repeat (30) tick();
    exp_medida = 12'h456;
    check("t5_pronto_once", pronto_cnt, p + 1);
    check("t5_zera_once", zera_cnt, z + 1);
    check("t5_idle", db_estado, 0);
    check("t5_medida", medida, exp_medida);

    // 5b: asynchronous reset in the middle of TRIGGER
    start_meas();
    repeat (4) tick();
    check("t5b_trigger_high", trigger, 1);
    #3 reset = 1'b1;
    #1;
    check("t5b_trigger_drop", trigger, 0);
    check("t5b_estado", db_estado, 0);
    check("t5b_medida", medida, 0);
    exp_medida = 12'h000;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // 6: fim_contador and timeout on the same clock
    p = pronto_cnt;
    start_meas();
    wait_fall();
    {d2, d1, d0} = 12'h789;
    repeat (5) tick();
    echo = 1'b1;
    repeat (TMO - 1 - 5) tick();
    check("t6_still_mede", db_estado, 4);
    fim_contador = 1'b1;
    tick();
    fim_contador = 1'b0;
    echo = 1'b0;
    check("t6_armazena", db_estado, 5);
    repeat (6) tick();
    exp_medida = 12'h789;
    check("t6_pronto", pronto_cnt, p + 1);
    check("t6_erro", erro, 0);
    check("t6_medida", medida, exp_medida);

    // Randomized measurements against the outcome model
    for (int k = 0; k < 6; k++) begin
      mode = $urandom_range(0, 3);
      p = pronto_cnt;
      start_meas();
      wait_fall();
      if (mode == 0) begin
        wait_erro();
        repeat (3) tick();
        check("rnd_timeout_no_pronto", pronto_cnt, p);
        check("rnd_timeout_erro", erro, 1);
      end else begin
        cm = $urandom_range(0, 999);
        dly = $urandom_range(0, 300);
        width = $urandom_range(1, 1500);
        echo_meas(dly, width, bcd_of(cm));
        exp_medida = bcd_of(cm);
        check("rnd_pronto", pronto_cnt, p + 1);
        check("rnd_erro", erro, 0);
      end
      check("rnd_medida", medida, exp_medida);
      check("rnd_idle", db_estado, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
